// File: rtl/biker_motion_ctrl.sv
// biker_motion_ctrl: per-biker sequencer that produces the sprite position,
// turn bitmap selects and flash colour mask once per frame.
// States: IDLE (frozen), RIDE (moving), TURN (turn animation), HIT (flashing).
// Optional feature macro: BIKER_WOBBLE_EN - when defined, topLeftY wobbles
// between INIT_Y and INIT_Y+1 while riding; when undefined Y is constant.
module biker_motion_ctrl #(
    parameter logic [10:0] INIT_X       = 11'd100,
    parameter logic [10:0] INIT_Y       = 11'd200,
    parameter logic [3:0]  SPEED_X      = 4'd2,
    parameter logic [10:0] X_MIN        = 11'd0,
    parameter logic [10:0] X_MAX        = 11'd607,
    parameter logic [7:0]  TURN_FRAMES  = 8'd16,
    parameter logic [7:0]  FLASH_FRAMES = 8'd32,
    parameter logic [7:0]  HIT_MASK     = 8'h49
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        collision,
    input  logic [3:0]  HitEdgeCode,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        turnLeft,
    output logic        turnRight,
    output logic [7:0]  colorMask,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RIDE = 2'd1,
        ST_TURN = 2'd2,
        ST_HIT  = 2'd3
    } state_t;

    // Edge code bit positions
    localparam int E_LEFT   = 3;
    localparam int E_TOP    = 2;
    localparam int E_RIGHT  = 1;
    localparam int E_BOTTOM = 0;

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic        dir_q, dir_d;          // 0 = moving right, 1 = moving left
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  pend_q, pend_d;        // OR-accumulated edge codes seen this frame
    logic        turn_l_q, turn_l_d;
    logic        turn_r_q, turn_r_d;
    logic [7:0]  mask_q, mask_d;

`ifdef BIKER_WOBBLE_EN
    logic [10:0] y_q, y_d;
    logic [2:0]  wob_q, wob_d;          // counts riding frames between Y toggles
`endif

    // Candidate positions, computed in 12 bits so a left move never wraps
    logic [11:0] x_ext;
    logic [11:0] x_right_sum;
    logic [11:0] x_left_diff;
    logic [11:0] x_left_limit;
    logic [10:0] x_moved;
    logic        dir_match;
    logic        at_bound;
    logic        hit_event;
    logic [3:0]  coll_bits;
    logic [7:0]  cnt_inc;

    // Movement arithmetic and event qualification for the current frame
    always_comb begin
        x_ext        = {1'b0, x_q};
        x_right_sum  = x_ext + {8'd0, SPEED_X};
        x_left_diff  = x_ext - {8'd0, SPEED_X};
        x_left_limit = {1'b0, X_MIN} + {8'd0, SPEED_X};
        if (dir_q == 1'b0) begin
            x_moved = (x_right_sum > {1'b0, X_MAX}) ? X_MAX : x_right_sum[10:0];
        end else begin
            x_moved = (x_ext < x_left_limit) ? X_MIN : x_left_diff[10:0];
        end
        hit_event = pend_q[E_TOP] | pend_q[E_BOTTOM];
        dir_match = dir_q ? pend_q[E_LEFT] : pend_q[E_RIGHT];
        at_bound  = dir_q ? (x_q == X_MIN) : (x_q == X_MAX);
        coll_bits = collision ? HitEdgeCode : 4'h0;
        cnt_inc   = cnt_q + 8'd1;
    end

    // Next-state and next-output logic; enable low overrides every state
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        turn_l_d = turn_l_q;
        turn_r_d = turn_r_q;
        mask_d   = mask_q;
`ifdef BIKER_WOBBLE_EN
        y_d      = y_q;
        wob_d    = wob_q;
`endif
        if (!enable) begin
            state_d  = ST_IDLE;
            cnt_d    = 8'd0;
            pend_d   = 4'h0;
            turn_l_d = 1'b0;
            turn_r_d = 1'b0;
            mask_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RIDE;
                    pend_d  = 4'h0;
                end
                ST_RIDE: begin
                    if (startOfFrame) begin
                        if (hit_event) begin
                            state_d = ST_HIT;
                            cnt_d   = 8'd0;
                            mask_d  = 8'd0;
                            pend_d  = 4'h0;
                        end else if (dir_match || at_bound) begin
                            state_d  = ST_TURN;
                            cnt_d    = 8'd0;
                            turn_r_d = ~dir_q;
                            turn_l_d = dir_q;
                            pend_d   = 4'h0;
                        end else begin
                            // Pending bits are consumed each frame; a collision
                            // arriving with this frame pulse waits for the next.
                            x_d    = x_moved;
                            pend_d = coll_bits;
`ifdef BIKER_WOBBLE_EN
                            wob_d  = wob_q + 3'd1;
                            if (wob_q == 3'd7) begin
                                y_d = (y_q == INIT_Y) ? (INIT_Y + 11'd1) : INIT_Y;
                            end
`endif
                        end
                    end else begin
                        pend_d = pend_q | coll_bits;
                    end
                end
                ST_TURN: begin
                    if (startOfFrame) begin
                        if (cnt_q == TURN_FRAMES - 8'd1) begin
                            state_d  = ST_RIDE;
                            dir_d    = ~dir_q;
                            cnt_d    = 8'd0;
                            turn_l_d = 1'b0;
                            turn_r_d = 1'b0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_HIT: begin
                    if (startOfFrame) begin
                        if (cnt_q == FLASH_FRAMES - 8'd1) begin
                            state_d = ST_RIDE;
                            cnt_d   = 8'd0;
                            mask_d  = 8'd0;
                        end else begin
                            cnt_d  = cnt_inc;
                            mask_d = cnt_inc[2] ? HIT_MASK : 8'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
`ifdef BIKER_WOBBLE_EN
        // Vibration only applies while riding
        if (state_d != ST_RIDE) begin
            y_d   = INIT_Y;
            wob_d = 3'd0;
        end
`endif
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            x_q      <= INIT_X;
            dir_q    <= 1'b0;
            cnt_q    <= 8'd0;
            pend_q   <= 4'h0;
            turn_l_q <= 1'b0;
            turn_r_q <= 1'b0;
            mask_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            turn_l_q <= turn_l_d;
            turn_r_q <= turn_r_d;
            mask_q   <= mask_d;
        end
    end

`ifdef BIKER_WOBBLE_EN
    // Wobble registers
    always_ff @(posedge clk) begin
        if (!resetN) begin
            y_q   <= INIT_Y;
            wob_q <= 3'd0;
        end else begin
            y_q   <= y_d;
            wob_q <= wob_d;
        end
    end

    assign topLeftY = y_q;
`else
    assign topLeftY = INIT_Y;
`endif

    assign topLeftX  = x_q;
    assign turnLeft  = turn_l_q;
    assign turnRight = turn_r_q;
    assign colorMask = mask_q;
    assign state     = state_q;

endmodule

// File: tb/tb_biker_motion_ctrl.sv
// Self-checking bench for biker_motion_ctrl: a table of collision/frame steps
// with hand-computed expected outputs, plus hand-written corner sequences.
// Instance dut starts at X=100; instance dut_b starts at X=603 for the
// right-boundary turn.
module tb_biker_motion_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        enable = 1'b0;
    logic        sof = 1'b0;
    logic        coll = 1'b0;
    logic [3:0]  code = 4'h0;
    logic        sof_b = 1'b0;
    logic        coll_b = 1'b0;
    logic [3:0]  code_b = 4'h0;

    logic [10:0] x_a, y_a, x_b, y_b;
    logic        tl_a, tr_a, tl_b, tr_b;
    logic [7:0]  m_a, m_b;
    logic [1:0]  st_a, st_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    biker_motion_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(enable),
        .collision(coll), .HitEdgeCode(code),
        .topLeftX(x_a), .topLeftY(y_a), .turnLeft(tl_a), .turnRight(tr_a),
        .colorMask(m_a), .state(st_a)
    );

    biker_motion_ctrl #(.INIT_X(11'd603)) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof_b), .enable(enable),
        .collision(coll_b), .HitEdgeCode(code_b),
        .topLeftX(x_b), .topLeftY(y_b), .turnLeft(tl_b), .turnRight(tr_b),
        .colorMask(m_b), .state(st_b)
    );

    typedef struct {
        logic        do_coll;
        logic [3:0]  code;
        int          frames;
        logic [10:0] ex;
        logic [1:0]  st;
        logic        tl;
        logic        tr;
        logic [7:0]  mask;
    } vec_t;

    vec_t vecs[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_a(input int n);
        for (int i = 0; i < n; i++) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            tick();
        end
    endtask

    task automatic frame_b(input int n);
        for (int i = 0; i < n; i++) begin
            sof_b = 1'b1;
            tick();
            sof_b = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_coll(input logic [3:0] c);
        coll = 1'b1;
        code = c;
        tick();
        coll = 1'b0;
        code = 4'h0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_a(input string tag, input int ex, input int st,
                           input int tl, input int tr, input int mask);
        chk({tag, " x"}, int'(x_a), ex);
`ifndef BIKER_WOBBLE_EN
        chk({tag, " y"}, int'(y_a), 200);
`endif
        chk({tag, " state"}, int'(st_a), st);
        chk({tag, " turnLeft"}, int'(tl_a), tl);
        chk({tag, " turnRight"}, int'(tr_a), tr);
        chk({tag, " mask"}, int'(m_a), mask);
        $display("step %s: x=%0d y=%0d state=%0d tl=%0d tr=%0d mask=%0h",
                 tag, x_a, y_a, st_a, tl_a, tr_a, m_a);
    endtask

    task automatic check_b(input string tag, input int ex, input int st,
                           input int tl, input int tr);
        chk({tag, " x"}, int'(x_b), ex);
        chk({tag, " state"}, int'(st_b), st);
        chk({tag, " turnLeft"}, int'(tl_b), tl);
        chk({tag, " turnRight"}, int'(tr_b), tr);
        chk({tag, " mask"}, int'(m_b), 0);
        $display("step %s: x=%0d state=%0d tl=%0d tr=%0d",
                 tag, x_b, st_b, tl_b, tr_b);
    endtask

    initial begin
        //            coll  code  frames  X    st  tl  tr  mask
        vecs[0]  = '{1'b0, 4'h0, 10, 11'd120, 2'd1, 1'b0, 1'b0, 8'h00}; // plain ride
        vecs[1]  = '{1'b1, 4'h8,  1, 11'd122, 2'd1, 1'b0, 1'b0, 8'h00}; // left edge ignored
        vecs[2]  = '{1'b0, 4'h0,  3, 11'd128, 2'd1, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 4'h4,  1, 11'd128, 2'd3, 1'b0, 1'b0, 8'h00}; // top -> HIT
        vecs[4]  = '{1'b0, 4'h0,  3, 11'd128, 2'd3, 1'b0, 1'b0, 8'h00}; // cnt 3
        vecs[5]  = '{1'b0, 4'h0,  1, 11'd128, 2'd3, 1'b0, 1'b0, 8'h49}; // cnt 4
        vecs[6]  = '{1'b0, 4'h0,  3, 11'd128, 2'd3, 1'b0, 1'b0, 8'h49}; // cnt 7
        vecs[7]  = '{1'b0, 4'h0,  1, 11'd128, 2'd3, 1'b0, 1'b0, 8'h00}; // cnt 8
        vecs[8]  = '{1'b0, 4'h0, 23, 11'd128, 2'd3, 1'b0, 1'b0, 8'h49}; // cnt 31
        vecs[9]  = '{1'b0, 4'h0,  1, 11'd128, 2'd1, 1'b0, 1'b0, 8'h00}; // back to RIDE
        vecs[10] = '{1'b0, 4'h0,  1, 11'd130, 2'd1, 1'b0, 1'b0, 8'h00}; // dir still right
        vecs[11] = '{1'b1, 4'h6,  1, 11'd130, 2'd3, 1'b0, 1'b0, 8'h00}; // top+right -> HIT
        vecs[12] = '{1'b0, 4'h0, 32, 11'd130, 2'd1, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{1'b1, 4'h2,  1, 11'd130, 2'd2, 1'b0, 1'b1, 8'h00}; // right edge -> TURN
        vecs[14] = '{1'b0, 4'h0, 15, 11'd130, 2'd2, 1'b0, 1'b1, 8'h00};
        vecs[15] = '{1'b0, 4'h0,  1, 11'd130, 2'd1, 1'b0, 1'b0, 8'h00}; // now going left
        vecs[16] = '{1'b0, 4'h0,  2, 11'd126, 2'd1, 1'b0, 1'b0, 8'h00};
        vecs[17] = '{1'b1, 4'h2,  1, 11'd124, 2'd1, 1'b0, 1'b0, 8'h00}; // right edge ignored
        vecs[18] = '{1'b1, 4'h8,  1, 11'd124, 2'd2, 1'b1, 1'b0, 8'h00}; // left edge -> TURN

        // Reset
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        check_a("reset", 100, 0, 0, 0, 0);
        check_b("reset_b", 603, 0, 0, 0);

        enable = 1'b1;
        tick();
        check_a("enable", 100, 1, 0, 0, 0);

        for (int r = 0; r < 19; r++) begin
            if (vecs[r].do_coll) pulse_coll(vecs[r].code);
            frame_a(vecs[r].frames);
            check_a($sformatf("row%0d", r), vecs[r].ex, vecs[r].st,
                    vecs[r].tl, vecs[r].tr, vecs[r].mask);
        end

        // Mid-TURN reset
        frame_a(5);
        check_a("turn_f5", 124, 2, 1, 0, 0);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        check_a("midturn_reset", 100, 0, 0, 0, 0);
        tick();
        check_a("after_reset", 100, 1, 0, 0, 0);

        // Enable low during HIT
        frame_a(3);
        check_a("ride3", 106, 1, 0, 0, 0);
        pulse_coll(4'h1);
        frame_a(1);
        check_a("bottom_hit", 106, 3, 0, 0, 0);
        frame_a(4);
        check_a("hit_cnt4", 106, 3, 0, 0, 8'h49);
        enable = 1'b0;
        tick();
        check_a("disable", 106, 0, 0, 0, 0);
        frame_a(2);
        check_a("frozen", 106, 0, 0, 0, 0);
        enable = 1'b1;
        tick();
        check_a("reenable", 106, 1, 0, 0, 0);
        frame_a(1);
        check_a("reenable_move", 108, 1, 0, 0, 0);

        // Collision on the same cycle as the frame pulse waits a frame
        sof  = 1'b1;
        coll = 1'b1;
        code = 4'h4;
        tick();
        sof  = 1'b0;
        coll = 1'b0;
        code = 4'h0;
        tick();
        check_a("same_cycle", 110, 1, 0, 0, 0);
        frame_a(1);
        check_a("same_cycle_next", 110, 3, 0, 0, 0);

        // Right boundary turn on dut_b
        check_b("b_start", 603, 1, 0, 0);
        frame_b(1);
        check_b("b_605", 605, 1, 0, 0);
        frame_b(1);
        check_b("b_607", 607, 1, 0, 0);
        frame_b(1);
        check_b("b_turn", 607, 2, 0, 1);
        frame_b(15);
        check_b("b_turn16", 607, 2, 0, 1);
        frame_b(1);
        check_b("b_turn_done", 607, 1, 0, 0);
        frame_b(1);
        check_b("b_left1", 605, 1, 0, 0);
        frame_b(1);
        check_b("b_left2", 603, 1, 0, 0);
`ifndef BIKER_WOBBLE_EN
        chk("b y", int'(y_b), 200);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
